// File: rtl/apb_mem_store_if.sv
// -----------------------------------------------------------------------------
// apb_mem_store_if
// Strobe-level bus between the APB bridge slave (master side) and the
// apb_mem_store storage array (slave side).
//   mem_wr / mem_rd    : one transfer per cycle the strobe is high
//   mem_be             : per-byte write enables, bit i covers bits [8i+7:8i]
//   mem_address        : byte address
//   mem_data_in        : write data
//   mem_data_out       : read data, qualified by mem_rvalid
//   mem_busy           : storage is zero-filling itself and ignores traffic
//   mem_err            : one-cycle pulse flagging an illegal access
// -----------------------------------------------------------------------------
interface apb_mem_store_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    mem_wr;
  logic                    mem_rd;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic                    mem_rvalid;
  logic                    mem_busy;
  logic                    mem_err;

  modport master (
    output mem_wr, mem_rd, mem_be, mem_address, mem_data_in,
    input  mem_data_out, mem_rvalid, mem_busy, mem_err
  );

  modport slave (
    input  mem_wr, mem_rd, mem_be, mem_address, mem_data_in,
    output mem_data_out, mem_rvalid, mem_busy, mem_err
  );
endinterface

// File: rtl/apb_mem_store.sv
// -----------------------------------------------------------------------------
// apb_mem_store
// Word-organised, byte-maskable storage array fed by the APB bridge strobes.
// After every reset it zero-fills itself (mem_busy high for DEPTH cycles),
// then services reads and writes. Read data emerges RD_LATENCY cycles after
// the sampled mem_rd, qualified by a one-cycle mem_rvalid. Illegal accesses
// raise a registered one-cycle mem_err pulse.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : apb_mem_store_if slave modport (strobes, read data, status)
// -----------------------------------------------------------------------------
module apb_mem_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_mem_store_if.slave   bus
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BE_W);
  localparam int IDX_W    = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Address decode. The full shifted address is compared so that set upper
  // bits never alias onto a low word.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;

  assign word_addr = bus.mem_address >> OFF_BITS;
  assign in_range  = (word_addr < ADDR_WIDTH'(DEPTH));
  assign word_idx  = word_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The sweep counter only advances during INIT and wraps
  // back to 0 on the transition, since DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The array has a single write port shared by the sweep and
  // by bus writes; reads are dropped whenever a write is presented alongside.
  // ---------------------------------------------------------------------------
  logic                  busy;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_W-1:0]       wr_be;
  logic                  rd_accept;
  logic                  err_d, err_q;

  always_comb begin
    busy      = (state_q == ST_INIT);
    wr_en     = 1'b0;
    wr_idx    = word_idx;
    wr_data   = bus.mem_data_in;
    wr_be     = bus.mem_be;
    rd_accept = 1'b0;
    err_d     = 1'b0;
    if (busy) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_data = '0;
      wr_be   = '1;
      err_d   = bus.mem_wr | bus.mem_rd;
    end else begin
      wr_en     = bus.mem_wr & in_range;
      rd_accept = bus.mem_rd & ~bus.mem_wr;
      err_d     = (bus.mem_wr | bus.mem_rd) &
                  (~in_range | (bus.mem_wr & bus.mem_rd));
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // NOTE: the array has no reset; clearing it is the job of the INIT sweep,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_array[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Out-of-range reads are still answered, with zero data.
  assign rd_word = in_range ? mem_array[word_idx] : '0;

  // ---------------------------------------------------------------------------
  // Read pipeline. Each data stage only loads when the stage before it holds
  // a valid read, so the last stage keeps the most recent read data between
  // reads and drives mem_data_out directly.
  // ---------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_d [RD_LATENCY];

  always_comb begin
    pipe_vld_d  = '0;
    pipe_data_d = pipe_data_q;
    pipe_vld_d[0] = rd_accept;
    if (rd_accept) begin
      pipe_data_d[0] = rd_word;
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      if (pipe_vld_q[i-1]) begin
        pipe_data_d[i] = pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      err_q       <= err_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  assign bus.mem_data_out = pipe_data_q[RD_LATENCY-1];
  assign bus.mem_rvalid   = pipe_vld_q[RD_LATENCY-1];
  assign bus.mem_busy     = busy;
  assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_apb_mem_store.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_store
// Directed bench for apb_mem_store (DEPTH 256, RD_LATENCY 3). Reads push their
// expected data and arrival cycle onto a scoreboard queue; a negedge monitor
// pops and compares whenever mem_rvalid is seen, and flags any rvalid that
// nothing was expected for.
// -----------------------------------------------------------------------------
module tb_apb_mem_store;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  apb_mem_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_mem_store #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", bus.mem_data_out, mon_e.data);
        check("rd_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] be);
    bus.mem_wr      = 1'b1;
    bus.mem_address = addr;
    bus.mem_data_in = data;
    bus.mem_be      = be;
    step();
    bus.mem_wr = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    exp_t e;
    bus.mem_rd      = 1'b1;
    bus.mem_address = addr;
    e.data = exp;
    e.cyc  = cyc + RD_LAT;
    sb.push_back(e);
    step();
    bus.mem_rd = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (RD_LAT + 1) step();
  endtask

  task automatic wait_sweep(input int exp_err_pulses);
    int n  = 0;
    int ne = 0;
    while (bus.mem_busy === 1'b1 && n < 400) begin
      step();
      n++;
      if (bus.mem_err === 1'b1) ne++;
    end
    check("busy_cycles", 32'(n), 32'(DEPTH));
    check("sweep_err_pulses", 32'(ne), 32'(exp_err_pulses));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.mem_wr      = 1'b0;
    bus.mem_rd      = 1'b1;
    bus.mem_be      = '0;
    bus.mem_address = '0;
    bus.mem_data_in = '0;

    // Reset state, with a read held high throughout reset and the sweep.
    repeat (3) step();
    check("rst_busy", 32'(bus.mem_busy), 32'd1);
    check("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    check("rst_err", 32'(bus.mem_err), 32'd0);
    check("rst_data_out", bus.mem_data_out, 32'h0);
    rst_n = 1'b1;
    wait_sweep(DEPTH);

    // Busy has just dropped with mem_rd still high: this is the first read.
    e.data = 32'h0;
    e.cyc  = cyc + RD_LAT;
    sb.push_back(e);
    step();
    bus.mem_rd = 1'b0;
    check("first_read_err", 32'(bus.mem_err), 32'd0);
    drain();

    // Byte-masked overwrite.
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    check("wr_full_err", 32'(bus.mem_err), 32'd0);
    wr(32'h10, 32'h11223344, 4'b0101);
    rd(32'h10, 32'hDE22BE44);
    drain();

    // Back-to-back reads in issue order.
    wr(32'h0, 32'h0A0A_0001, 4'hF);
    wr(32'h4, 32'h1B1B_0002, 4'hF);
    wr(32'h8, 32'h2C2C_0003, 4'hF);
    wr(32'hC, 32'h3D3D_0004, 4'hF);
    rd(32'h0, 32'h0A0A_0001);
    rd(32'h4, 32'h1B1B_0002);
    rd(32'h8, 32'h2C2C_0003);
    rd(32'hC, 32'h3D3D_0004);
    drain();

    // Out-of-range accesses.
    rd(32'h400, 32'h0);
    check("oor_rd_err", 32'(bus.mem_err), 32'd1);
    step();
    check("err_one_cycle", 32'(bus.mem_err), 32'd0);
    wr(32'h400, 32'hFFFF_FFFF, 4'hF);
    check("oor_wr_err", 32'(bus.mem_err), 32'd1);
    wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
    check("oor_hi_wr_err", 32'(bus.mem_err), 32'd1);
    rd(32'h0, 32'h0A0A_0001);
    check("inrange_rd_err", 32'(bus.mem_err), 32'd0);
    drain();

    // Simultaneous write and read: write wins, read dropped.
    bus.mem_wr      = 1'b1;
    bus.mem_rd      = 1'b1;
    bus.mem_address = 32'h20;
    bus.mem_data_in = 32'hA5A5_A5A5;
    bus.mem_be      = 4'hF;
    step();
    bus.mem_wr = 1'b0;
    bus.mem_rd = 1'b0;
    check("wr_rd_err", 32'(bus.mem_err), 32'd1);
    repeat (RD_LAT + 1) step();
    wr(32'h20, 32'h0, 4'h0);
    check("be_zero_err", 32'(bus.mem_err), 32'd0);
    rd(32'h20, 32'hA5A5_A5A5);
    rd(32'h23, 32'hA5A5_A5A5);
    drain();

    // Reset while a read is in flight.
    wr(32'h8, 32'h0000_0055, 4'hF);
    rd(32'h8, 32'h0000_0055);
    drain();
    bus.mem_rd      = 1'b1;
    bus.mem_address = 32'h8;
    step();
    bus.mem_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.mem_busy), 32'd1);
    check("midrst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    repeat (RD_LAT + 1) step();
    rst_n = 1'b1;
    wait_sweep(0);
    rd(32'h8, 32'h0);
    rd(32'h10, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_store.md
Name: apb_mem_store

Overview:
- Word-organised, byte-maskable storage array that sits directly downstream of the APB bridge's slave and consumes its mem_wr/mem_rd/mem_be/mem_address/mem_data_in strobes.
- Read data returns on mem_data_out after a fixed, parameterised latency, qualified by mem_rvalid.
- After every reset it zero-fills itself with an internal sweep before accepting traffic.
- It flags illegal accesses on a one-cycle error pulse.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, width of the byte address on mem_address.
- DEPTH, 256, number of words; power of two, at least 2.
- RD_LATENCY, 1, cycles from the sampled mem_rd to mem_rvalid; legal range 1..4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_wr  input  1  write strobe, one transfer per cycle it is high.
- mem_rd  input  1  read strobe, one transfer per cycle it is high.
- mem_be  input  DATA_WIDTH/8  byte enables for writes; bit i covers data bits [8i+7:8i].
- mem_address  input  ADDR_WIDTH  byte address.
- mem_data_in  input  DATA_WIDTH  write data.
- mem_data_out  output  DATA_WIDTH  read data.
- mem_rvalid  output  1  one-cycle pulse when mem_data_out carries new read data.
- mem_busy  output  1  high while the zero-fill sweep runs.
- mem_err  output  1  one-cycle error pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - mem_data_out = 0, mem_rvalid = 0, mem_err = 0, mem_busy = 1.
  - FSM = INIT, sweep counter = 0, read pipeline flushed.
  - The array itself is not reset asynchronously.
- Address decode:
  - Word index = mem_address >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - The access is out of range when the word index is DEPTH or greater, with the upper address bits included in the compare.
- FSM, two states:
  - INIT: each cycle writes all-zero to word[cnt], then cnt increments. On the cycle cnt == DEPTH-1 the FSM moves to READY. mem_busy is high for exactly DEPTH cycles after rst_n deasserts, then drops to 0.
  - READY: services accesses. The FSM stays in READY until the next reset.
- Write (READY, mem_wr = 1, in range):
  - At the clock edge, each byte with mem_be[i] = 1 takes mem_data_in; other bytes keep their value.
  - mem_be = 0 is a legal no-op and raises no error.
- Read (READY, mem_rd = 1, in range):
  - Array word is sampled in the mem_rd cycle and carried through a RD_LATENCY-deep pipeline.
  - mem_data_out updates and mem_rvalid pulses exactly RD_LATENCY cycles after the mem_rd edge.
  - Read-old semantics: a read and a write to the same word in the same cycle cannot both be accepted (see errors). A read issued the cycle after a write returns the new data.
  - Back-to-back reads are accepted every cycle, giving a continuous mem_rvalid stream.
  - mem_data_out holds its last value between reads.
- Error cases: mem_err pulses one cycle after the offending edge, i.e. registered.
  - Out-of-range write: array is unchanged.
  - Out-of-range read: the read is still answered. mem_data_out = 0 and mem_rvalid pulses at normal latency.
  - mem_wr and mem_rd in the same cycle: the write is performed and the read is dropped, with no mem_rvalid.
  - Any mem_wr or mem_rd while mem_busy = 1: the access is dropped and the sweep continues unaffected.
  - Multiple causes in one cycle give a single pulse.
- Reset mid-operation:
  - Pipeline is flushed; no mem_rvalid emerges for reads in flight.
  - FSM returns to INIT and the sweep restarts at word 0.
  - Prior contents are zeroed by the sweep.

Test Plan:
- Release rst_n, hold mem_rd = 1 at address 0 throughout → mem_busy high for exactly 256 cycles. mem_err pulses each busy cycle with no mem_rvalid. The first read after busy falls returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with be = 4'hF, then write 0x11223344 with be = 4'b0101, then read 0x10 → mem_data_out = 0xDE22BE44, with mem_rvalid exactly RD_LATENCY cycles after the read.
- RD_LATENCY = 3: four consecutive reads of 0x0, 0x4, 0x8, 0xC holding distinct values → four consecutive mem_rvalid pulses starting 3 cycles after the first read, data in issue order.
- Read address 0x400 (word 256, DEPTH = 256) → mem_data_out = 0, mem_rvalid = 1, mem_err = 1. A write to 0x400 leaves word 0 unchanged and pulses mem_err.
- Same-cycle mem_wr and mem_rd to 0x20 with data 0xA5A5A5A5 → mem_err pulses and no mem_rvalid. A following read of 0x20 returns 0xA5A5A5A5.
- Assert rst_n = 0 while a read is in flight after writing 0x55 to 0x8 → no mem_rvalid appears, mem_busy rises, and after the sweep a read of 0x8 returns 0.
